warp_scheduler: RTL
===================

// Module: warp_scheduler
// PURPOSE
// Arbitrates the single shared core pipeline (scheduler/fetcher/decoder/ALUs) between NUM_WARPS warps.
// Produces warp_select for the warp-state controller, which saves and restores per-warp context.
// Switches warps at instruction boundaries, on a memory stall (latency hiding), on warp completion, or on quantum expiry.
// Raises all_done when every launched warp has finished.
// PARAMETERS
// NUM_WARPS  2  warps sharing the pipeline; power of two, >=2
// QUANTUM    8  max consecutive instructions issued for one warp before a forced rotation; >=1
// PORTS
// clk            in   1                   core clock; all state updates on posedge
// reset          in   1                   synchronous, active-high
// warp_start     in   NUM_WARPS           level; warp i launched and runnable until done
// warp_done      in   NUM_WARPS           level; warp i has executed RET (saved done flag)
// mem_pending    in   NUM_WARPS           warp i has >=1 LSU thread in REQUESTING/WAITING
// core_state     in   3 (corestate_t)     live state of the pipeline for the selected warp
// warp_select    out  $clog2(NUM_WARPS)   warp currently owning the pipeline
// pipe_hold      out  1                   1 = pipeline must not advance (switch bubble / nothing runnable)
// switch_pulse   out  1                   1-cycle pulse on the cycle warp_select changes
// all_done       out  1                   every started warp is done
// BEHAVIOUR
// - Reset values: warp_select=0, pipe_hold=1, switch_pulse=0, all_done=0, quantum count=0, FSM=S_IDLE.
// - runnable[i] = warp_start[i] & ~warp_done[i] & ~mem_pending[i].
// - Boundary cycle: core_state==CORE_UPDATE (instruction retire) or core_state==CORE_WAIT (memory stall).
// - FSM:
//   S_IDLE:   pipe_hold=1. If any runnable: warp_select <= lowest-index runnable, switch_pulse, -> S_SWITCH.
//   S_RUN:    pipe_hold=0. Quantum count +1 on each CORE_UPDATE cycle (saturates at QUANTUM).
//             Switch request when any of: core_state==CORE_WAIT & another warp runnable;
//             core_state==CORE_DONE; CORE_UPDATE & count==QUANTUM-1 & another warp runnable.
//             On request: pick next runnable warp round-robin starting at warp_select+1 (wraps mod NUM_WARPS),
//             excluding current; warp_select <= pick, count <= 0, switch_pulse=1, -> S_SWITCH.
//             If current finished/stalled and no other warp is runnable: -> S_IDLE (CORE_WAIT stays in S_RUN;
//             current warp simply waits on its own LSU).
//   S_SWITCH: exactly 1 cycle, pipe_hold=1, gives the negedge context save/restore a full cycle; -> S_RUN.
// - Switch latency: request cycle N -> warp_select new at N+1 -> pipeline resumes at N+2.
// - Quantum expiry with no other runnable warp: count resets to 0, no switch, no bubble.
// - Never switches mid-instruction (FETCH/DECODE/REQUEST/EXECUTE); warp_select is stable outside boundaries.
// - Simultaneous: WAIT-stall and quantum expiry in one cycle -> one switch, count reset once.
// - A stalled warp becomes re-eligible the cycle after mem_pending falls; it waits its round-robin turn.
// - all_done registered: 1 when |warp_start and for all i, warp_start[i] -> warp_done[i]; FSM then holds S_IDLE.
// - warp_start deasserting for the selected warp forces an S_IDLE transition at the next boundary.
// - reset mid-operation: all state returns to reset values the next posedge regardless of FSM state.
// TESTING
// 1. reset=1 two cycles, warp_start=00 -> warp_select=0, pipe_hold=1, all_done=0, switch_pulse never pulses.
// 2. warp_start=11, no memory ops, QUANTUM=8 -> 8 CORE_UPDATEs on warp0, switch_pulse, 1 hold cycle, warp1 runs; alternates 0,1,0.
// 3. warp0 enters CORE_WAIT with mem_pending=01, warp1 runnable -> warp_select=1 next cycle, pipe_hold=1 for 1 cycle.
// 4. Both warps mem_pending=11 -> selected warp stays, pipe_hold=0 in CORE_WAIT; warp1 pending clears -> switch at warp0's next WAIT/UPDATE.
// 5. warp0 reaches CORE_DONE with warp_done=01 -> switch to warp1; warp1 done (11) -> all_done=1, S_IDLE, pipe_hold=1.
// 6. NUM_WARPS=4, warp_start=1011, selected=3 at quantum expiry -> wrap picks warp 0; then 1; warp 2 never selected.

Source files
------------

// File: rtl/warp_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | warp_scheduler_if : warp-state and pipeline-status bundle for the scheduler  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface warp_scheduler_if #(
  parameter int NUM_WARPS = 2
) ();
  localparam int SEL_W = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0] warp_start;
  logic [NUM_WARPS-1:0] warp_done;
  logic [NUM_WARPS-1:0] mem_pending;
  logic [2:0]           core_state;
  logic [SEL_W-1:0]     warp_select;
  logic                 pipe_hold;
  logic                 switch_pulse;
  logic                 all_done;

  modport master (
    output warp_start, warp_done, mem_pending, core_state,
    input  warp_select, pipe_hold, switch_pulse, all_done
  );

  modport slave (
    input  warp_start, warp_done, mem_pending, core_state,
    output warp_select, pipe_hold, switch_pulse, all_done
  );
endinterface
`default_nettype wire

// File: rtl/warp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | warp_scheduler : time-multiplexes the shared core pipeline across warps     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module warp_scheduler #(
  parameter int NUM_WARPS = 2,
  parameter int QUANTUM   = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  warp_scheduler_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_WARPS);
  localparam int CNT_W = $clog2(QUANTUM + 1);

  localparam logic [2:0]       CORE_WAIT   = 3'd4;
  localparam logic [2:0]       CORE_UPDATE = 3'd6;
  localparam logic [2:0]       CORE_DONE   = 3'd7;
  localparam logic [CNT_W-1:0] Q_LAST      = CNT_W'(QUANTUM - 1);
  localparam logic [CNT_W-1:0] Q_MAX       = CNT_W'(QUANTUM);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  state_t           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] count_q;
  logic             hold_q;
  logic             pulse_q;
  logic             all_done_q;

  logic [NUM_WARPS-1:0] runnable_d;
  logic [NUM_WARPS-1:0] others_d;
  logic [SEL_W-1:0]     lowest_d;
  logic [SEL_W-1:0]     rr_d;
  logic [SEL_W-1:0]     idx_d;
  logic                 any_other_d;
  logic                 all_done_d;
  logic                 is_wait_d;
  logic                 is_update_d;
  logic                 is_done_d;
  logic                 expire_d;
  logic                 cur_started_d;

  always_comb begin
    runnable_d  = bus.warp_start & ~bus.warp_done & ~bus.mem_pending;
    others_d    = runnable_d & ~(NUM_WARPS'(1) << sel_q);
    any_other_d = |others_d;
    all_done_d  = (|bus.warp_start) & (&(~bus.warp_start | bus.warp_done));

    lowest_d = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (runnable_d[i]) lowest_d = SEL_W'(i);
    end

    // Scan downward in distance so the nearest warp after the current one wins.
    rr_d  = sel_q;
    idx_d = sel_q;
    for (int k = NUM_WARPS - 1; k >= 1; k--) begin
      idx_d = sel_q + SEL_W'(k);
      if (others_d[idx_d]) rr_d = idx_d;
    end

    is_wait_d     = (bus.core_state == CORE_WAIT);
    is_update_d   = (bus.core_state == CORE_UPDATE);
    is_done_d     = (bus.core_state == CORE_DONE);
    expire_d      = is_update_d && (count_q == Q_LAST);
    cur_started_d = bus.warp_start[sel_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      count_q    <= '0;
      hold_q     <= 1'b1;
      pulse_q    <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      pulse_q    <= 1'b0;
      all_done_q <= all_done_d;
      case (state_q)
        S_IDLE: begin
          hold_q  <= 1'b1;
          count_q <= '0;
          if (|runnable_d) begin
            sel_q   <= lowest_d;
            pulse_q <= 1'b1;
            state_q <= S_SWITCH;
          end
        end
        S_SWITCH: begin
          hold_q  <= 1'b0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          // A warp whose launch was withdrawn is dropped at the next boundary.
          if ((is_wait_d || is_update_d) && !cur_started_d) begin
            hold_q  <= 1'b1;
            count_q <= '0;
            state_q <= S_IDLE;
          end else if (is_done_d || ((is_wait_d || expire_d) && any_other_d)) begin
            count_q <= '0;
            hold_q  <= 1'b1;
            if (any_other_d) begin
              sel_q   <= rr_d;
              pulse_q <= 1'b1;
              state_q <= S_SWITCH;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (is_update_d) begin
            if (expire_d)
              count_q <= '0;
            else if (count_q < Q_MAX)
              count_q <= count_q + 1'b1;
          end
        end
        default: begin
          hold_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.warp_select  = sel_q;
  assign bus.pipe_hold    = hold_q;
  assign bus.switch_pulse = pulse_q;
  assign bus.all_done     = all_done_q;
endmodule
`default_nettype wire
